// File: rtl/aes_engine_param.sv
// Iterative AES encryptor with a per-key expanded schedule, one round per clock.
// Supports ECB / CBC-encrypt / CTR chaining with ready/valid on both sides.
module aes_engine_param #(
  parameter int KEY_BITS = 256,
  parameter int CTR_BITS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key,
  input  logic [1:0]   key_mode,
  input  logic         key_valid,
  input  logic [127:0] iv,
  input  logic         iv_load,
  input  logic         clear,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         key_ready,
  output logic         busy
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK6 = 6'(NK);
  localparam logic [3:0] NR4 = 4'(NR);
  localparam logic [127:0] CMASK = {128{1'b1}} >> (128 - CTR_BITS);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_engine_param: KEY_BITS must be 128, 192 or 256");
  end
  if (CTR_BITS < 1 || CTR_BITS > 128) begin : g_bad_ctr
    $error("aes_engine_param: CTR_BITS must be 1..128");
  end

  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_READY, S_ENC} state_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t state, state_nx;
  logic [31:0]  w [NW];
  logic [5:0]   widx;
  logic [2:0]   kpos;
  logic [7:0]   rcon;
  logic [3:0]   round, ri;
  logic [1:0]   mode;
  logic [127:0] st, chain, saved, rk, blk_in, rnd_out;
  logic [31:0]  w_prev, w_back, sub_in, sub_out, w_new;
  logic [15:0][7:0] sb_out, sr, mc;
  logic [5:0]   rbase;
  logic         idle_rdy, key_load, accept, kexp_last, enc_out, last_rnd;
  logic         is_cbc, is_ctr, key_unused;

  // Only the top KEY_BITS of key are meaningful; the rest is intentionally dropped.
  assign key_unused = ^key;

  assign idle_rdy  = (state == S_IDLE) || (state == S_READY);
  assign key_load  = idle_rdy && key_valid;
  assign in_ready  = (state == S_READY) && !out_valid && !key_valid && !iv_load;
  assign accept    = in_valid && in_ready;
  assign kexp_last = (widx == 6'(NW - 1));
  assign enc_out   = (round == 4'(NR + 1));
  assign last_rnd  = (round == NR4);
  assign busy      = (state == S_KEXP) || (state == S_ENC);
  assign is_cbc    = (mode == 2'd1);
  assign is_ctr    = (mode == 2'd2);
  assign blk_in    = is_cbc ? (in_data ^ chain) : (is_ctr ? chain : in_data);

  // Key schedule: one word per cycle, SubWord shared through 4 sboxes
  assign w_prev = w[widx - 6'd1];
  assign w_back = w[widx - NK6];
  assign sub_in = (kpos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_ksb
    aes_sbox u_ksb (.a(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
  end

  always_comb begin
    w_new = w_back ^ w_prev;
    if (kpos == 3'd0) w_new = w_back ^ sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && kpos == 3'd4) w_new = w_back ^ sub_out;
  end

  // Round key 0 is used at accept, clamp once past the last round
  assign ri    = (state == S_ENC) ? ((round > NR4) ? NR4 : round) : 4'd0;
  assign rbase = {ri, 2'b00};
  assign rk    = {w[rbase], w[rbase + 6'd1], w[rbase + 6'd2], w[rbase + 6'd3]};

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb_out[4*((c+r)%4)+r];
    end
    assign mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
  end

  for (genvar g = 0; g < 16; g++) begin : g_byte
    aes_sbox u_sb (.a(st[127-8*g -: 8]), .y(sb_out[g]));
    assign rnd_out[127-8*g -: 8] = (last_rnd ? sr[g] : mc[g]) ^ rk[127-8*g -: 8];
  end

  always_comb begin
    state_nx = state;
    if (clear) state_nx = S_IDLE;
    else begin
      case (state)
        S_IDLE, S_READY: begin
          if (key_valid) state_nx = S_KEXP;
          else if (accept) state_nx = S_ENC;
        end
        S_KEXP:  if (kexp_last) state_nx = S_READY;
        S_ENC:   if (enc_out) state_nx = S_READY;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (key_load && !clear) begin
      for (int k = 0; k < NK; k++) w[k] <= key[255-32*k -: 32];
    end else if (state == S_KEXP) begin
      w[widx] <= w_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx <= '0; kpos <= '0; rcon <= 8'h01; round <= '0; mode <= '0;
      st <= '0; chain <= '0; saved <= '0;
      out_data <= '0; out_valid <= 1'b0; key_ready <= 1'b0;
    end else if (clear) begin
      chain <= '0; round <= '0;
      out_valid <= 1'b0; key_ready <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (idle_rdy && iv_load) chain <= iv;
      case (state)
        S_IDLE, S_READY: begin
          if (key_valid) begin
            widx <= NK6; kpos <= '0; rcon <= 8'h01; key_ready <= 1'b0;
            mode <= (key_mode == 2'd3) ? 2'd0 : key_mode;
          end else if (accept) begin
            st <= blk_in ^ rk; saved <= in_data; round <= 4'd1;
          end
        end
        S_KEXP: begin
          widx <= widx + 6'd1;
          kpos <= (kpos == 3'(NK - 1)) ? 3'd0 : kpos + 3'd1;
          if (kpos == 3'd0) rcon <= xt(rcon);
          if (kexp_last) key_ready <= 1'b1;
        end
        S_ENC: begin
          if (enc_out) begin
            out_data  <= is_ctr ? (st ^ saved) : st;
            out_valid <= 1'b1;
            if (is_cbc) chain <= st;
            if (is_ctr) chain <= ((chain + 128'd1) & CMASK) | (chain & ~CMASK);
          end else begin
            st <= rnd_out; round <= round + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// AES S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, xx, zz;
    p = '0; xx = x; zz = z;
    for (int i = 0; i < 8; i++) begin
      if (zz[0]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
      zz = zz >> 1;
    end
    return p;
  endfunction

  logic [7:0] inv;
  always_comb begin
    logic [7:0] p;
    p   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
  end

  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// File: tb/tb_aes_engine_param.sv
// Directed bench: FIPS-197 / SP800-38A vectors across key sizes, modes, backpressure, clear, reset.
module tb_aes_engine_param;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] key;
  logic [1:0]   key_mode;
  logic [3:0]   key_valid, in_valid;
  logic [127:0] iv, in_data;
  logic         iv_load, clear, out_ready;
  logic [3:0]   in_ready, out_valid, key_ready, busy;
  logic [127:0] out_data [4];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  aes_engine_param #(.KEY_BITS(128), .CTR_BITS(32)) u_d0 (
    .clk(clk), .rst_n(rst_n), .key(key), .key_mode(key_mode), .key_valid(key_valid[0]),
    .iv(iv), .iv_load(iv_load), .clear(clear), .in_data(in_data), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .key_ready(key_ready[0]), .busy(busy[0]));
  aes_engine_param #(.KEY_BITS(192), .CTR_BITS(32)) u_d1 (
    .clk(clk), .rst_n(rst_n), .key(key), .key_mode(key_mode), .key_valid(key_valid[1]),
    .iv(iv), .iv_load(iv_load), .clear(clear), .in_data(in_data), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .key_ready(key_ready[1]), .busy(busy[1]));
  aes_engine_param #(.KEY_BITS(256), .CTR_BITS(32)) u_d2 (
    .clk(clk), .rst_n(rst_n), .key(key), .key_mode(key_mode), .key_valid(key_valid[2]),
    .iv(iv), .iv_load(iv_load), .clear(clear), .in_data(in_data), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready), .key_ready(key_ready[2]), .busy(busy[2]));
  aes_engine_param #(.KEY_BITS(128), .CTR_BITS(8)) u_d3 (
    .clk(clk), .rst_n(rst_n), .key(key), .key_mode(key_mode), .key_valid(key_valid[3]),
    .iv(iv), .iv_load(iv_load), .clear(clear), .in_data(in_data), .in_valid(in_valid[3]),
    .in_ready(in_ready[3]), .out_data(out_data[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready), .key_ready(key_ready[3]), .busy(busy[3]));

  localparam logic [255:0] K_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K_SP   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_key(input int d, input logic [255:0] k, input logic [1:0] m,
                          input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    key = k; key_mode = m; key_valid[d] = 1'b1;
    @(negedge clk);
    key_valid[d] = 1'b0;
    chk({tag, "_busy"}, 128'(busy[d]), 128'd1);
    lat = 0;
    while (!key_ready[d] && lat < 200) begin @(negedge clk); lat++; end
    chk({tag, "_klat"}, 128'(lat), 128'(exp_lat));
  endtask

  task automatic load_iv(input logic [127:0] v);
    @(negedge clk);
    iv = v; iv_load = 1'b1;
    @(negedge clk);
    iv_load = 1'b0;
  endtask

  task automatic enc(input int d, input logic [127:0] pt, input logic [127:0] exp,
                     input int exp_lat, input bit chk_data, input string tag);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready[d] && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, 128'(in_ready[d]), 128'd1);
    in_data = pt; in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    chk({tag, "_busy"}, 128'(busy[d]), 128'd1);
    n = 0;
    while (!out_valid[d] && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 128'(n), 128'(exp_lat));
    if (chk_data) chk({tag, "_data"}, out_data[d], exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    key = '0; key_mode = '0; key_valid = '0; in_valid = '0; iv = '0; in_data = '0;
    iv_load = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_ctl", 128'({in_ready[d], out_valid[d], key_ready[d], busy[d]}), 128'd0);
      chk("rst_data", out_data[d], 128'd0);
    end
    rst_n = 1'b1;

    load_key(0, K_FIPS, 2'd0, 40, "k128");
    enc(0, PT, CT128, 11, 1'b1, "ecb128");
    load_key(1, K_FIPS, 2'd0, 46, "k192");
    enc(1, PT, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 13, 1'b1, "ecb192");
    load_key(2, K_FIPS, 2'd0, 52, "k256");
    enc(2, PT, 128'h8ea2b7ca516745bfeafc49904b496089, 15, 1'b1, "ecb256");
    load_key(0, K_FIPS, 2'd3, 40, "kmode3");
    enc(0, PT, CT128, 11, 1'b1, "mode3");

    load_key(0, K_SP, 2'd1, 40, "kcbc");
    load_iv(128'h000102030405060708090a0b0c0d0e0f);
    enc(0, P1, 128'h7649abac8119b246cee98e9b12e9197d, 11, 1'b1, "cbc1");
    enc(0, P2, 128'h5086cb9b507219ee95db113a917678b2, 11, 1'b1, "cbc2");

    load_key(0, K_SP, 2'd2, 40, "kctr");
    load_iv(128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    enc(0, P1, 128'h874d6191b620e3261bef6864990db6ce, 11, 1'b1, "ctr1");
    enc(0, P2, 128'h9806f66b7970fdff8617187bb9fffdff, 11, 1'b1, "ctr2");

    // 8-bit counter: ...ff wraps to all-zero block, whose zero-key ciphertext is known
    load_key(3, 256'h0, 2'd2, 40, "kctr8");
    load_iv(128'h000000000000000000000000000000ff);
    enc(3, 128'h0, 128'h0, 11, 1'b0, "ctr8a");
    enc(3, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 11, 1'b1, "ctr8b");

    load_key(0, K_FIPS, 2'd0, 40, "kbp");
    out_ready = 1'b0;
    enc(0, PT, CT128, 11, 1'b1, "bp1");
    in_data = PT; in_valid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_data", out_data[0], CT128);
      chk("bp_hold_ctl", 128'({out_valid[0], in_ready[0]}), 128'd2);
    end
    out_ready = 1'b1;
    n = 0;
    while (!in_ready[0] && n < 10) begin @(negedge clk); n++; end
    chk("bp_pop", 128'({out_valid[0], in_ready[0]}), 128'd1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("bp2_busy", 128'(busy[0]), 128'd1);
    n = 0;
    while (!out_valid[0] && n < 100) begin @(negedge clk); n++; end
    chk("bp2_lat", 128'(n), 128'd11);
    chk("bp2_data", out_data[0], CT128);

    // clear in the middle of a block
    @(negedge clk);
    n = 0;
    while (!in_ready[0] && n < 10) begin @(negedge clk); n++; end
    in_data = PT; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_enc", 128'({in_ready[0], out_valid[0], key_ready[0], busy[0]}), 128'd0);
    repeat (15) @(negedge clk);
    chk("clr_enc_after", 128'({out_valid[0], key_ready[0]}), 128'd0);

    // clear in the middle of key expansion
    key = K_FIPS; key_mode = 2'd0; key_valid[1] = 1'b1;
    @(negedge clk);
    key_valid[1] = 1'b0;
    repeat (10) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_kexp", 128'({key_ready[1], busy[1]}), 128'd0);
    repeat (60) @(negedge clk);
    chk("clr_kexp_after", 128'({key_ready[1], busy[1]}), 128'd0);

    // reset asserted mid-encrypt
    load_key(0, K_FIPS, 2'd0, 40, "krst");
    @(negedge clk);
    in_data = PT; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", 128'({in_ready[0], out_valid[0], key_ready[0], busy[0]}), 128'd0);
    chk("rst_mid_data", out_data[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_mid_after", 128'({out_valid[0], key_ready[0], busy[0]}), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
